// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_pkg                                                   |
// | Purpose  : Shared lookahead constants, P/G pair type and the         |
// |            group-level carry function for the pipelined CLA adder.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cla_pkg;

  // Width of one lookahead group; cla_block is hard-wired for this value.
  localparam int c_GRP_W = 4;

  // Group propagate / generate pair.
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Carry out of a lookahead group from its P/G pair and its carry-in.
  function automatic logic cla_group_carry(input pg_t pg, input logic cin);
    return pg.g | (pg.p & cin);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_block                                                 |
// | Purpose  : Combinational 4-bit carry-lookahead group. Produces the   |
// |            sum bits plus group propagate/generate for the next level.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module cla_block
  import cla_pkg::*;
(
  input  logic [c_GRP_W-1:0] a,
  input  logic [c_GRP_W-1:0] b,
  input  logic               cin,
  output logic [c_GRP_W-1:0] sum,
  output logic               p,
  output logic               g
);

  logic [c_GRP_W-1:0] w_p;
  logic [c_GRP_W-1:0] w_g;
  logic [c_GRP_W-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Internal carries are flattened two-level lookahead, not a ripple chain.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

  // Group terms let the enclosing stage chain groups without the bit carries.
  assign p = &w_p;
  assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_pipe_adder                                            |
// | Purpose  : Pipelined carry-lookahead adder/subtractor, valid/ready   |
// |            stream, one operand slice resolved per stage, signed      |
// |            overflow flag. Define CLA_PIPE_SAT_EN to saturate z on    |
// |            overflow.                                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / c_GRP_W;
  localparam int LAST  = STAGES - 1;

  // Stage input registers: r_a/r_b carry the still-unprocessed operand
  // slices forward (skew), r_s carries the finished lower sum slices (deskew).
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  // Next-load values for each stage register bank.
  logic [WIDTH-1:0]  w_a_in [STAGES];
  logic [WIDTH-1:0]  w_b_in [STAGES];
  logic [WIDTH-1:0]  w_s_in [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;

  // Per-stage results: partial sum with own slice filled in, slice carry-out.
  logic [WIDTH-1:0]  w_s_nx [STAGES];
  logic [STAGES-1:0] w_co;

  logic             w_advance;
  logic             w_cmsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_z;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  // Subtraction is x + ~y + ~cin, so borrow-in arrives as an inverted carry.
  assign w_a_in[0] = x;
  assign w_b_in[0] = sub ? ~y : y;
  assign w_c_in[0] = sub ? ~cin : cin;
  assign w_s_in[0] = '0;
  assign w_v_in[0] = in_valid;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [NGRP:0]      w_gc;
      logic [NGRP-1:0]    w_gp;
      logic [NGRP-1:0]    w_gg;
      logic [SLICE-1:0]   w_sum;
      logic [WIDTH-1:0]   w_snext;

      assign w_gc[0] = r_c[k];

      for (genvar j = 0; j < NGRP; j++) begin : g_grp
        pg_t w_pg;

        cla_block u_grp (
          .a   (r_a[k][k*SLICE + j*c_GRP_W +: c_GRP_W]),
          .b   (r_b[k][k*SLICE + j*c_GRP_W +: c_GRP_W]),
          .cin (w_gc[j]),
          .sum (w_sum[j*c_GRP_W +: c_GRP_W]),
          .p   (w_gp[j]),
          .g   (w_gg[j])
        );

        assign w_pg       = '{p: w_gp[j], g: w_gg[j]};
        assign w_gc[j+1]  = cla_group_carry(w_pg, w_gc[j]);
      end

      // Splice this stage's sum slice into the travelling result word.
      always_comb begin
        w_snext                     = r_s[k];
        w_snext[k*SLICE +: SLICE]   = w_sum;
      end

      assign w_s_nx[k] = w_snext;
      assign w_co[k]   = w_gc[NGRP];

      if (k < LAST) begin : g_fwd
        assign w_a_in[k+1] = r_a[k];
        assign w_b_in[k+1] = r_b[k];
        assign w_s_in[k+1] = w_s_nx[k];
        assign w_c_in[k+1] = w_co[k];
        assign w_v_in[k+1] = r_v[k];
      end
    end
  endgenerate

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign w_cmsb = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ w_s_nx[LAST][WIDTH-1];
  assign w_ovf  = w_cmsb ^ w_co[LAST];

`ifdef CLA_PIPE_SAT_EN
  // Clamp toward the sign of operand A when the signed result overflows.
  assign w_z = w_ovf ? {r_a[LAST][WIDTH-1], {(WIDTH-1){~r_a[LAST][WIDTH-1]}}}
                     : w_s_nx[LAST];
`else
  assign w_z = w_s_nx[LAST];
`endif

  // Stage banks and output register all load together on advance.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < STAGES; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
      end
      r_c         <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_advance) begin
      for (int i = 0; i < STAGES; i++) begin
        r_a[i] <= w_a_in[i];
        r_b[i] <= w_b_in[i];
        r_s[i] <= w_s_in[i];
      end
      r_c         <= w_c_in;
      r_v         <= w_v_in;
      r_out_valid <= r_v[LAST];
      r_z         <= w_z;
      r_cout      <= w_co[LAST];
      r_ovf       <= w_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cla_pipe_adder                                         |
// | Purpose  : Self-checking bench for cla_pipe_adder (16 bit, 4 stages) |
// |            with an arithmetic reference model and scoreboard.        |
// |            Honours CLA_PIPE_SAT_EN for saturation expectations.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_cla_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [15:0] z;
    logic        c;
    logic        o;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] got[$];

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic s);
    res_t r;
    int   ua, ub, sa, sb, ur, sr;
    ua = int'({16'h0000, a});
    ub = int'({16'h0000, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ur  = ua - ub - int'(ci);
      sr  = sa - sb - int'(ci);
      r.c = (ur >= 0);
    end else begin
      ur  = ua + ub + int'(ci);
      sr  = sa + sb + int'(ci);
      r.c = (ur > 65535);
    end
    r.z = ur[15:0];
    r.o = (sr > 32767) || (sr < -32768);
`ifdef CLA_PIPE_SAT_EN
    if (r.o) r.z = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: inputs/outputs are stable at the falling edge and describe
  // what the next rising edge will do.
  logic        stall_pend = 1'b0;
  logic [15:0] stall_z = '0;
  res_t        e;

  always @(negedge clk) begin
    if (!res) begin
      exp_q.delete();
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_hold_z", 32'(z), 32'(stall_z));
        check("stall_hold_valid", 32'(out_valid), 32'd1);
      end
      stall_pend = out_valid && !out_ready;
      stall_z    = z;
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        got.push_back(z);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got z=%h want no beat", z);
        end else begin
          e = exp_q.pop_front();
          check("sb_z", 32'(z), 32'(e.z));
          check("sb_cout", 32'(cout), 32'(e.c));
          check("sb_ovf", 32'(ovf), 32'(e.o));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with literal expectations and exact latency.
  task automatic run_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s,
                         input logic [15:0] ez, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    x = a; y = b; cin = ci; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(STAGES));
    check({nm, "_z"}, 32'(z), 32'(ez));
    check({nm, "_cout"}, 32'(cout), 32'(ec));
    check({nm, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
  endtask

  initial begin
    int   i;
    int   cyc;
    logic acc;

    // Reset with a beat offered: nothing may come out.
    #2 res = 1'b0;
    in_valid = 1'b1; x = 16'h0001; y = 16'h0002;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'h0000);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    res = 1'b1; in_valid = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    run_one("add_1_2",   16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    run_one("ripple",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("sub_5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_7_5",   16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_one("sub_borrow",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
`ifdef CLA_PIPE_SAT_EN
    run_one("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_one("ovf_neg",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    run_one("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("ovf_neg",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Back-pressure: 8 beats x=y=i, out_ready alternating 1,0,1,0...
    got.delete();
    i = 0; cyc = 0;
    while ((i < 8 || exp_q.size() != 0) && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      if (i < 8) begin
        x = 16'(i); y = 16'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #3 acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_no_timeout", 32'(cyc < 200), 32'd1);
    check("bp_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      check("bp_value", 32'(got[k]), 32'(2 * k));

    // Reset mid-stream: in-flight beats must vanish.
    for (int k = 0; k < 6; k++) begin
      x = 16'(k + 100); y = 16'h0001; in_valid = 1'b1;
      tick();
    end
    res = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_z", 32'(z), 32'h0000);
    in_valid = 1'b0;
    tick();
    res = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Everything accepted must have been emitted.
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
